// File: rtl/candidate_delay_buffer.sv
// Multi-lane delay buffer for the FME candidate path with tap-selectable delay,
// valid tracking, flush and occupancy count. Define CAND_BUF_BEST_EN to add the registered minimum-lane finder.
module candidate_delay_buffer #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 8,
    parameter int DEPTH     = 8,
    parameter int SELW      = $clog2(DEPTH)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           flush,
    input  logic [SELW-1:0]                delay_sel,
    input  logic [LANES*DATAWIDTH-1:0]     in_data,
    input  logic                           in_valid,
    output logic [LANES*DATAWIDTH-1:0]     out_data,
    output logic                           out_valid,
    output logic [$clog2(DEPTH+1)-1:0]     fill_count
`ifdef CAND_BUF_BEST_EN
    ,
    output logic [$clog2(LANES)-1:0]       best_idx,
    output logic [DATAWIDTH-1:0]           best_val,
    output logic                           best_valid
`endif
);

    localparam int CNTW = $clog2(DEPTH + 1);

    logic [LANES*DATAWIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0]           valid;
    logic [CNTW-1:0]            count;
    logic [SELW-1:0]            tap;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            valid <= '0;
            count <= '0;
        end else if (enable) begin
            stage[0] <= in_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
            valid <= {valid[DEPTH-2:0], in_valid};
            // Entry/exit pairing keeps the count equal to the number of valid stages.
            if (in_valid && !valid[DEPTH-1]) begin
                count <= count + CNTW'(1);
            end else if (!in_valid && valid[DEPTH-1]) begin
                count <= count - CNTW'(1);
            end
        end
    end

    // Out-of-range selects only exist when DEPTH is not a power of two.
    always_comb begin
        tap = delay_sel;
        if (int'(delay_sel) > DEPTH - 1) begin
            tap = SELW'(DEPTH - 1);
        end
    end

    assign out_data   = stage[tap];
    assign out_valid  = valid[tap];
    assign fill_count = count;

`ifdef CAND_BUF_BEST_EN
    localparam int IDXW = $clog2(LANES);

    logic [DATAWIDTH-1:0] min_val;
    logic [IDXW-1:0]      min_idx;

    // Strict less-than keeps the lowest lane index on ties.
    always_comb begin
        min_val = out_data[0 +: DATAWIDTH];
        min_idx = '0;
        for (int unsigned i = 1; i < LANES; i++) begin
            if (out_data[i*DATAWIDTH +: DATAWIDTH] < min_val) begin
                min_val = out_data[i*DATAWIDTH +: DATAWIDTH];
                min_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            best_idx   <= '0;
            best_val   <= '0;
            best_valid <= 1'b0;
        end else begin
            best_idx   <= min_idx;
            best_val   <= min_val;
            best_valid <= out_valid;
        end
    end
`endif

endmodule

// File: tb/tb_candidate_delay_buffer.sv
// Scoreboard bench for candidate_delay_buffer: a reference chain model plus a FIFO
// of valid words checked as they reach the last stage. Best-finder checks need CAND_BUF_BEST_EN.
module tb_candidate_delay_buffer;

    localparam int DW = 8;
    localparam int L  = 8;
    localparam int D  = 8;
    localparam int SW = 3;
    localparam int CW = 4;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset, enable, flush, in_valid;
    logic [SW-1:0] delay_sel;
    logic [L*DW-1:0] in_data;
    logic [L*DW-1:0] out_data;
    logic          out_valid;
    logic [CW-1:0] fill_count;
`ifdef CAND_BUF_BEST_EN
    logic [IW-1:0] best_idx;
    logic [DW-1:0] best_val;
    logic          best_valid;
`endif

    candidate_delay_buffer #(.DATAWIDTH(DW), .LANES(L), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .delay_sel  (delay_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .fill_count (fill_count)
`ifdef CAND_BUF_BEST_EN
        ,
        .best_idx   (best_idx),
        .best_val   (best_val),
        .best_valid (best_valid)
`endif
    );

    always #5 clock = ~clock;

    logic [L*DW-1:0] m_data [D];
    logic            m_valid [D];
    logic [IW-1:0]   m_bidx;
    logic [DW-1:0]   m_bval;
    logic            m_bvalid;
    logic [L*DW-1:0] sb_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [L*DW-1:0] mk(input int n);
        logic [L*DW-1:0] w;
        for (int i = 0; i < L; i++) w[i*DW +: DW] = DW'(8*n + i);
        return w;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
        m_bidx = '0; m_bval = '0; m_bvalid = 1'b0;
        sb_q.delete();
    endtask

    task automatic step(input logic rst, input logic en, input logic fl, input logic v,
                        input logic [L*DW-1:0] d, input logic [SW-1:0] sel);
        logic [L*DW-1:0] pre_out, sb_exp;
        logic            pre_v, sb_hit;
        int              tap, pc;
        reset = rst; enable = en; flush = fl; in_valid = v; in_data = d; delay_sel = sel;
        tap = (int'(sel) >= D) ? D - 1 : int'(sel);
        pre_out = m_data[tap];
        pre_v   = m_valid[tap];
        sb_hit  = 1'b0;
        sb_exp  = '0;
        @(posedge clock);
        if (rst || fl) begin
            model_clear();
        end else begin
            m_bval = pre_out[DW-1:0];
            m_bidx = '0;
            for (int i = 1; i < L; i++) begin
                if (pre_out[i*DW +: DW] < m_bval) begin
                    m_bval = pre_out[i*DW +: DW];
                    m_bidx = IW'(i);
                end
            end
            m_bvalid = pre_v;
            if (en) begin
                if (v) sb_q.push_back(d);
                for (int k = D - 1; k > 0; k--) begin
                    m_data[k]  = m_data[k-1];
                    m_valid[k] = m_valid[k-1];
                end
                m_data[0]  = d;
                m_valid[0] = v;
                if (m_valid[D-1]) begin
                    check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                    if (sb_q.size() > 0) begin
                        sb_exp = sb_q.pop_front();
                        sb_hit = (int'(sel) == D - 1);
                    end
                end
            end
        end
        #1;
        pc = 0;
        for (int k = 0; k < D; k++) pc += int'(m_valid[k]);
        check("out_data", out_data, m_data[tap]);
        check("out_valid", 64'(out_valid), 64'(m_valid[tap]));
        check("fill_count", 64'(fill_count), 64'(pc));
        if (sb_hit) check("sb_word", out_data, sb_exp);
`ifdef CAND_BUF_BEST_EN
        check("best_idx", 64'(best_idx), 64'(m_bidx));
        check("best_val", 64'(best_val), 64'(m_bval));
        check("best_valid", 64'(best_valid), 64'(m_bvalid));
`endif
    endtask

    initial begin
        logic [L*DW-1:0] junk;
        int              pat [5] = '{1, 0, 1, 1, 0};
        model_clear();
        reset = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; delay_sel = '0;

        // reset state
        step(1, 0, 0, 0, '0, 3'd7);
        step(1, 1, 0, 1, mk(99), 3'd7);
        check("rst_fill", 64'(fill_count), 64'd0);

        // streaming at full delay; out_valid rises on the 8th enabled edge
        for (int n = 0; n < 12; n++) begin
            step(0, 1, 0, 1, mk(n), 3'd7);
            if (n == 6) check("lat_pre", 64'(out_valid), 64'd0);
            if (n == 7) begin
                check("lat_first", out_data, mk(0));
                check("lat_full", 64'(fill_count), 64'd8);
            end
        end

        // stall: junk inputs ignored, outputs frozen
        for (int s = 0; s < 3; s++) begin
            junk = {$urandom, $urandom};
            step(0, 0, 0, 1, junk, 3'd7);
            check("stall_hold", out_data, mk(4));
        end
        for (int n = 12; n < 16; n++) step(0, 1, 0, 1, mk(n), 3'd7);
        check("post_stall", out_data, mk(8));

        // tap switch while full, no enabled edges
        step(0, 0, 0, 0, '0, 3'd2);
        check("tap2", out_data, mk(13));
        step(0, 0, 0, 0, '0, 3'd7);
        check("tap7_back", out_data, mk(8));

        // bubbles, then drain
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 5; p++) step(0, 1, 0, pat[p][0], mk(20 + 5*r + p), 3'd7);
        for (int n = 0; n < 10; n++) step(0, 1, 0, 1'b0, mk(40 + n), 3'd7);
        check("drained", 64'(fill_count), 64'd0);

        // random enables, valids and taps
        for (int n = 0; n < 60; n++)
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom), {$urandom, $urandom}, 3'($urandom));

        // flush with fill_count at 5 and a valid input
        step(0, 0, 1, 0, '0, 3'd7);
        for (int n = 0; n < 5; n++) step(0, 1, 0, 1, mk(60 + n), 3'd7);
        check("pre_flush", 64'(fill_count), 64'd5);
        step(0, 1, 1, 1, mk(70), 3'd0);
        check("flush_fill", 64'(fill_count), 64'd0);
        check("flush_data", out_data, 64'd0);

        // reset mid-stream, then refill
        for (int n = 0; n < 4; n++) step(0, 1, 0, 1, mk(80 + n), 3'd3);
        step(1, 1, 0, 1, mk(90), 3'd3);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        for (int n = 0; n < 6; n++) step(0, 1, 0, 1, mk(100 + n), 3'd3);
        check("rst_refill", out_data, mk(102));

`ifdef CAND_BUF_BEST_EN
        step(0, 0, 1, 0, '0, 3'd0);
        step(0, 1, 0, 1, {8'd30, 8'd4, 8'd12, 8'd200, 8'd4, 8'd7, 8'd4, 8'd9}, 3'd0);
        step(0, 0, 0, 0, '0, 3'd0);
        check("best_idx_tie", 64'(best_idx), 64'd1);
        check("best_val_min", 64'(best_val), 64'd4);
        check("best_valid_on", 64'(best_valid), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
